// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: slice state encoding
// and the width of the occupancy counter.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slice_state_e;

    localparam int unsigned SLICE_CNT_W = 2;

    // Occupancy ranges 0..2*stages, so it needs clog2(2*stages+1) bits.
    function automatic int unsigned count_width(input int unsigned stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// One skid-buffered slice: a main register feeding the output and a skid
// register that absorbs the item arriving in the cycle the output stalls.
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    slice_state_e     state_r;
    slice_state_e     state_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic             accept_s;
    logic             fire_s;
    logic             load_main_in_s;
    logic             load_main_skid_s;
    logic             load_skid_s;

    // Ready never depends on out_ready; rst and flush force both handshakes off.
    assign in_ready  = rst & ~flush & (state_r != FULL);
    assign out_valid = ~flush & (state_r != EMPTY);
    assign out_data  = main_r;
    assign accept_s  = in_valid & in_ready;
    assign fire_s    = out_valid & out_ready;

    // Next-state and payload load-enable decode.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && fire_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s = FULL;
                        load_skid_s = 1'b1;
                    end else if (fire_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    if (fire_s) begin
                        state_nxt_s      = ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // Slice state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Payload registers; flush leaves their contents untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_r <= RESET_VAL;
            skid_r <= RESET_VAL;
        end else begin
            if (load_main_in_s) begin
                main_r <= in_data;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= in_data;
            end
        end
    end

    // Entry count decoded from the state flops.
    always_comb begin
        case (state_r)
            ONE:     count = 2'd1;
            FULL:    count = 2'd2;
            default: count = 2'd0;
        endcase
    end

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: STAGES skid slices in series with a shared
// synchronous flush and a total occupancy count.
module pipe_reg_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [count_width(STAGES)-1:0]   count
);

    localparam int CNT_W = count_width(STAGES);

    // Element i is the link into slice i; element STAGES is the block output.
    logic             valid_s     [STAGES+1];
    logic             ready_s     [STAGES+1];
    logic [WIDTH-1:0] data_s      [STAGES+1];
    logic [1:0]       slice_cnt_s [STAGES];
    logic [CNT_W-1:0] count_sum_s;

    assign valid_s[0]      = in_valid;
    assign data_s[0]       = in_data;
    assign in_ready        = ready_s[0];
    assign out_valid       = valid_s[STAGES];
    assign out_data        = data_s[STAGES];
    assign ready_s[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        pipe_slice #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_slice (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (valid_s[i]),
            .in_ready  (ready_s[i]),
            .in_data   (data_s[i]),
            .out_valid (valid_s[i+1]),
            .out_ready (ready_s[i+1]),
            .out_data  (data_s[i+1]),
            .count     (slice_cnt_s[i])
        );
    end

    // Total occupancy is the sum of the per-slice counts.
    always_comb begin
        count_sum_s = '0;
        for (int i = 0; i < STAGES; i++) begin
            count_sum_s = count_sum_s + CNT_W'(slice_cnt_s[i]);
        end
    end

    assign count = count_sum_s;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Self-checking bench for pipe_reg_elastic: directed scenarios plus random
// traffic checked against a FIFO queue model of the in-flight items.
module tb_pipe_reg_elastic;

    localparam int          WIDTH  = 32;
    localparam int          STAGES = 2;
    localparam int          CW     = $clog2(2 * STAGES + 1);
    localparam logic [31:0] RV     = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [CW-1:0] count;

    int          errors = 0;
    int          checks = 0;
    int          edge_n = 0;
    bit          acc_f;
    bit          fir_f;
    logic [31:0] q[$];

    pipe_reg_elastic #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic cycle();
        #3;
        acc_f = in_valid && in_ready;
        fir_f = out_valid && out_ready;
        if (flush) begin
            chk("flush_in_ready", 32'(in_ready), 32'd0);
            chk("flush_out_valid", 32'(out_valid), 32'd0);
        end
        if (fir_f) begin
            chk("fire_nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                chk("out_data", out_data, q[0]);
                void'(q.pop_front());
            end
        end
        if (acc_f) q.push_back(in_data);
        @(posedge clk);
        edge_n++;
        if (flush) q.delete();
        #1;
        chk("count", 32'(count), 32'(q.size()));
        if (q.size() == 0) chk("empty_out_valid", 32'(out_valid), 32'd0);
        if (q.size() == 2 * STAGES) chk("full_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int acc_edge;
        int first_v;
        int nf;
        int prev;
        int gaps;
        int maxc;

        // Reset with upstream offering data
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_data", out_data, RV);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);
        cycle();

        // Streaming 1..16 with out_ready held high
        out_ready = 1'b1; acc_edge = -1; first_v = -1; nf = 0; prev = 0; gaps = 0; maxc = 0;
        v = 1;
        for (int g = 0; g < 60; g++) begin
            in_valid = (v <= 16);
            in_data  = v;
            cycle();
            if (acc_f) begin
                if (v == 1) acc_edge = edge_n;
                v++;
            end
            if (fir_f) begin
                if (nf > 0 && edge_n != prev + 1) gaps++;
                prev = edge_n;
                nf++;
            end
            if (out_valid && first_v < 0) first_v = edge_n;
            if (int'(count) > maxc) maxc = int'(count);
            if (v > 16 && q.size() == 0) break;
        end
        chk("stream_latency", 32'(first_v - acc_edge), 32'(STAGES - 1));
        chk("stream_fires", 32'(nf), 32'd16);
        chk("stream_gaps", 32'(gaps), 32'd0);
        chk("stream_maxcount", 32'(maxc), 32'd2);

        // Fill under backpressure, then release
        out_ready = 1'b0; v = 10;
        for (int g = 0; g < 6; g++) begin
            in_valid = 1'b1;
            in_data  = v;
            cycle();
            if (acc_f) v++;
        end
        chk("fill_accepted", 32'(v - 10), 32'd4);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head", out_data, 32'd10);
        out_ready = 1'b1; nf = 0; gaps = 0;
        for (int g = 0; g < 20; g++) begin
            in_valid = (v <= 14);
            in_data  = v;
            cycle();
            if (acc_f) v++;
            if (fir_f) begin
                if (nf > 0 && edge_n != prev + 1) gaps++;
                prev = edge_n;
                nf++;
            end
            if (v > 14 && q.size() == 0) break;
        end
        chk("drain_fires", 32'(nf), 32'd5);
        chk("drain_gaps", 32'(gaps), 32'd0);

        // Simultaneous accept and fire at count 3
        out_ready = 1'b0; v = 20;
        for (int g = 0; g < 10 && q.size() < 3; g++) begin
            in_valid = 1'b1;
            in_data  = v;
            cycle();
            if (acc_f) v++;
        end
        chk("simul_pre_count", 32'(count), 32'd3);
        in_valid = 1'b1; in_data = v; out_ready = 1'b1;
        cycle();
        chk("simul_both", 32'(acc_f && fir_f), 32'd1);
        chk("simul_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        for (int g = 0; g < 20 && q.size() > 0; g++) cycle();
        chk("simul_drained", 32'(count), 32'd0);

        // Flush with both handshakes offered
        out_ready = 1'b0; v = 40;
        for (int g = 0; g < 10 && q.size() < 4; g++) begin
            in_valid = 1'b1;
            in_data  = v;
            cycle();
            if (acc_f) v++;
        end
        chk("flush_pre_count", 32'(count), 32'd4);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'd55; out_ready = 1'b1;
        cycle();
        chk("flush_no_xfer", 32'(acc_f || fir_f), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid_after", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 32'd99;
        cycle();
        chk("flush_accept99", 32'(acc_f), 32'd1);
        acc_edge = edge_n;
        in_valid = 1'b0;
        for (int g = 0; g < 6 && !out_valid; g++) cycle();
        chk("flush_latency99", 32'(edge_n - acc_edge), 32'(STAGES - 1));
        chk("flush_data99", out_data, 32'd99);
        for (int g = 0; g < 10 && q.size() > 0; g++) cycle();

        // Asynchronous reset between edges with three items held
        out_ready = 1'b0; v = 70;
        for (int g = 0; g < 10 && q.size() < 3; g++) begin
            in_valid = 1'b1;
            in_data  = v;
            cycle();
            if (acc_f) v++;
        end
        in_valid = 1'b0;
        chk("arst_pre_count", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_data", out_data, RV);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random traffic against the queue model
        for (int g = 0; g < 600; g++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = (g < 300) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int g = 0; g < 20 && q.size() > 0; g++) cycle();
        chk("final_count", 32'(count), 32'd0);
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
